// File: rtl/button_conditioner.sv
// Push-button front end: synchronises the raw pin, debounces it with a counter FSM,
// and produces a clean level plus one-cycle press, release and long-press pulses.
module button_conditioner #(
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t            state;
    logic [STAGES-1:0] sync;
    logic [DW-1:0]     deb_cnt;
    logic [HW-1:0]     hold_cnt;
    logic              n;
    logic              s;

    assign n = btn_raw ^ ACTIVE_LOW;
    assign s = sync[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], n};
        end
    end

    // deb_cnt is 0 in both stable states, so a stable state whose next sample
    // would already complete the count (DEBOUNCE_CYCLES == 1) accepts directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so each is high for exactly one cycle.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;

            case (state)
                IDLE, PRESS_WAIT: begin
                    if (s) begin
                        if (deb_cnt == DEB_LAST) begin
                            state       <= PRESSED;
                            deb_cnt     <= '0;
                            hold_cnt    <= '0;
                            btn_level   <= 1'b1;
                            press_pulse <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            state   <= PRESS_WAIT;
                            deb_cnt <= deb_cnt + 1'b1;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                        busy    <= 1'b0;
                    end
                end

                PRESSED, RELEASE_WAIT: begin
                    if (!s) begin
                        if (deb_cnt == DEB_LAST) begin
                            state         <= IDLE;
                            deb_cnt       <= '0;
                            btn_level     <= 1'b0;
                            release_pulse <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            state   <= RELEASE_WAIT;
                            deb_cnt <= deb_cnt + 1'b1;
                            busy    <= 1'b1;
                        end
                    end else begin
                        // A bounce back to pressed keeps hold_cnt frozen; it resumes next cycle.
                        if (state == PRESSED && hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 1'b1;
                            if (hold_cnt == HOLD_LAST) begin
                                hold_pulse <= 1'b1;
                            end
                        end
                        state   <= PRESSED;
                        deb_cnt <= '0;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected pulse edges are queued when the pin is
// driven and matched against every pulse the DUTs emit.
module tb_button_conditioner;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_HOLD    = 2;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic btn0, btn1;
    logic lvl0, pp0, rp0, hp0, busy0;
    logic lvl1, pp1, rp1, hp1, busy1;

    int errors   = 0;
    int checks   = 0;
    int edge_cnt = 0;
    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    button_conditioner #(
        .STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .ACTIVE_LOW(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .btn_raw(btn0),
        .btn_level(lvl0), .press_pulse(pp0), .release_pulse(rp0),
        .hold_pulse(hp0), .busy(busy0)
    );

    button_conditioner #(
        .STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .btn_raw(btn1),
        .btn_level(lvl1), .press_pulse(pp1), .release_pulse(rp1),
        .hold_pulse(hp1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic expect_ev(input int id, input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic observe(input int id, input int kind);
        ev_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            check($sformatf("dut%0d_unexpected_kind%0d", id, kind), edge_cnt, -1);
            return;
        end
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("dut%0d_pulse_kind", id), kind, e.kind);
        check($sformatf("dut%0d_pulse_edge_kind%0d", id, kind), edge_cnt, e.at);
    endtask

    always @(negedge clk) begin
        if (pp0) observe(0, K_PRESS);
        if (rp0) observe(0, K_RELEASE);
        if (hp0) observe(0, K_HOLD);
        if (pp1) observe(1, K_PRESS);
        if (rp1) observe(1, K_RELEASE);
        if (hp1) observe(1, K_HOLD);
    end

    task automatic wait_edge(input int t);
        while (edge_cnt < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k;
        int e;

        reset = 1'b1;
        btn0  = 1'b0;
        btn1  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_lvl0", lvl0, 0);
        check("reset_busy0", busy0, 0);
        check("reset_pp0", pp0, 0);
        check("reset_lvl1", lvl1, 0);
        check("reset_busy1", busy1, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_edge(edge_cnt + 3);

        // Clean press, long hold, clean release.
        k = edge_cnt;
        btn0 = 1'b1;
        expect_ev(0, K_PRESS, k + 6);
        expect_ev(0, K_HOLD, k + 14);
        expect_ev(0, K_RELEASE, k + 32);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            e = edge_cnt - k;
            check("s1_busy", busy0, (e >= 3 && e <= 5) ? 1 : 0);
            check("s1_level", lvl0, (e >= 6) ? 1 : 0);
        end
        wait_edge(k + 20);
        check("s1_held_level", lvl0, 1);
        check("s1_held_busy", busy0, 0);
        wait_edge(k + 26);
        btn0 = 1'b0;
        wait_edge(k + 31);
        @(negedge clk);
        check("s1_rel_wait_level", lvl0, 1);
        check("s1_rel_wait_busy", busy0, 1);
        @(negedge clk);
        check("s1_released_level", lvl0, 0);
        check("s1_released_busy", busy0, 0);
        wait_edge(k + 40);

        // Short glitch: three high samples never reach the debounce count.
        k = edge_cnt;
        btn0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (edge_cnt == k + 3) btn0 = 1'b0;
            @(negedge clk);
            check("s2_busy", busy0, (i >= 3 && i <= 5) ? 1 : 0);
            check("s2_level", lvl0, 0);
        end
        wait_edge(k + 12);

        // Release bounce while pressed: hold count freezes then resumes.
        k = edge_cnt;
        btn0 = 1'b1;
        expect_ev(0, K_PRESS, k + 6);
        expect_ev(0, K_HOLD, k + 17);
        expect_ev(0, K_RELEASE, k + 36);
        wait_edge(k + 9);
        btn0 = 1'b0;
        wait_edge(k + 11);
        btn0 = 1'b1;
        wait_edge(k + 12);
        @(negedge clk);
        check("s3_bounce_busy", busy0, 1);
        check("s3_bounce_level", lvl0, 1);
        wait_edge(k + 30);
        btn0 = 1'b0;
        wait_edge(k + 36);
        @(negedge clk);
        check("s3_released_level", lvl0, 0);
        wait_edge(k + 45);

        // Reset mid-debounce and mid-hold.
        k = edge_cnt;
        btn0 = 1'b1;
        wait_edge(k + 4);
        reset = 1'b1;
        @(negedge clk);
        check("s5_pre_reset_busy", busy0, 1);
        wait_edge(k + 5);
        reset = 1'b0;
        expect_ev(0, K_PRESS, k + 11);
        @(negedge clk);
        check("s5_reset1_level", lvl0, 0);
        check("s5_reset1_busy", busy0, 0);
        wait_edge(k + 16);
        check("s5_pre_reset2_level", lvl0, 1);
        reset = 1'b1;
        wait_edge(k + 17);
        reset = 1'b0;
        expect_ev(0, K_PRESS, k + 23);
        expect_ev(0, K_HOLD, k + 31);
        expect_ev(0, K_RELEASE, k + 41);
        @(negedge clk);
        check("s5_reset2_level", lvl0, 0);
        check("s5_reset2_busy", busy0, 0);
        wait_edge(k + 35);
        btn0 = 1'b0;
        wait_edge(k + 50);

        // Active-low pin on the second instance.
        k = edge_cnt;
        btn1 = 1'b0;
        expect_ev(1, K_PRESS, k + 6);
        expect_ev(1, K_RELEASE, k + 16);
        wait_edge(k + 10);
        btn1 = 1'b1;
        @(negedge clk);
        check("s6_level_pressed", lvl1, 1);
        wait_edge(k + 16);
        @(negedge clk);
        check("s6_level_released", lvl1, 0);
        wait_edge(k + 25);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
